// File: rtl/switch_mux_pkg.sv
// Shared types and constants for the break-before-make GPIO switch matrix.
package switch_mux_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } chan_state_t;

endpackage

// File: rtl/switch_mux_chan.sv
// One output channel: connection FSM, break-before-make gap counter and output flop.
module switch_mux_chan
  import switch_mux_pkg::*;
#(
  parameter int INPUT_COUNT = 4,
  parameter int GAP_CYCLES  = 4,
  parameter bit IDLE_LEVEL  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   req_en,
  input  logic [IDX_W-1:0]       req_sel,
  input  logic [INPUT_COUNT-1:0] din,
  output logic                   out_bit,
  output logic                   busy_bit
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  chan_state_t              state;
  logic [IDX_W-1:0]         sel;
  logic                     pend_en;
  logic [7:0]               cnt;
  logic [(1 << IDX_W)-1:0]  din_ext;

  // Widen to the full index range so a 4-bit select never reads past the vector.
  always_comb begin
    din_ext = '0;
    for (int i = 0; i < INPUT_COUNT; i++) din_ext[i] = din[i];
  end

  assign busy_bit = (state == ST_GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= '0;
      pend_en <= 1'b0;
      cnt     <= '0;
      out_bit <= IDLE_LEVEL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && req_en) begin
            state   <= ST_ACTIVE;
            sel     <= req_sel;
            out_bit <= din_ext[req_sel];
          end else begin
            out_bit <= IDLE_LEVEL;
          end
        end
        ST_ACTIVE: begin
          if (req && !req_en) begin
            state   <= ST_GAP;
            pend_en <= 1'b0;
            cnt     <= GAP_LOAD;
            out_bit <= IDLE_LEVEL;
          end else if (req && (req_sel != sel)) begin
            state   <= ST_GAP;
            pend_en <= 1'b1;
            sel     <= req_sel;
            cnt     <= GAP_LOAD;
            out_bit <= IDLE_LEVEL;
          end else begin
            out_bit <= din_ext[sel];
          end
        end
        ST_GAP: begin
          // The pending selection is already in sel; it only takes effect on exit.
          if (cnt == 8'd0) begin
            if (pend_en) begin
              state   <= ST_ACTIVE;
              out_bit <= din_ext[sel];
            end else begin
              state   <= ST_IDLE;
              out_bit <= IDLE_LEVEL;
            end
          end else begin
            cnt     <= cnt - 8'd1;
            out_bit <= IDLE_LEVEL;
          end
        end
        default: begin
          state   <= ST_IDLE;
          out_bit <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_mux.sv
// GPIO switch matrix: synchronised inputs routed to registered outputs, one
// break-before-make channel per output, reconfigured through a valid/ready port.
module switch_mux
  import switch_mux_pkg::*;
#(
  parameter int INPUT_COUNT  = 4,
  parameter int OUTPUT_COUNT = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int GAP_CYCLES   = 4,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_COUNT-1:0]  in,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [IDX_W-1:0]        cfg_out,
  input  logic [IDX_W-1:0]        cfg_sel,
  input  logic                    cfg_en,
  output logic                    cfg_err,
  output logic [OUTPUT_COUNT-1:0] out,
  output logic [OUTPUT_COUNT-1:0] busy
);

  localparam logic [IDX_W:0] OUT_LIM = (IDX_W + 1)'(OUTPUT_COUNT);
  localparam logic [IDX_W:0] IN_LIM  = (IDX_W + 1)'(INPUT_COUNT);

  logic [INPUT_COUNT-1:0]  sync_pipe [SYNC_STAGES];
  logic [(1 << IDX_W)-1:0] busy_ext;
  logic [OUTPUT_COUNT-1:0] req_vec;
  logic                    out_ok;
  logic                    sel_ok;
  logic                    accept;
  logic                    req_bad;

  // Input synchroniser: stage 0 is the metastability catcher.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= {INPUT_COUNT{IDLE_LEVEL}};
    end else begin
      sync_pipe[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
    end
  end

  always_comb begin
    busy_ext = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++) busy_ext[i] = busy[i];
  end

  assign out_ok    = ({1'b0, cfg_out} < OUT_LIM);
  assign sel_ok    = ({1'b0, cfg_sel} < IN_LIM);
  assign cfg_ready = out_ok ? ~busy_ext[cfg_out] : 1'b1;
  assign accept    = cfg_valid & cfg_ready;
  assign req_bad   = ~out_ok | (cfg_en & ~sel_ok);

  // Only a valid accepted request reaches a channel; invalid ones just flag cfg_err.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++)
      req_vec[i] = accept && !req_bad && (cfg_out == i[IDX_W-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= accept & req_bad;
  end

  for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : g_chan
    switch_mux_chan #(
      .INPUT_COUNT (INPUT_COUNT),
      .GAP_CYCLES  (GAP_CYCLES),
      .IDLE_LEVEL  (IDLE_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .req      (req_vec[g]),
      .req_en   (cfg_en),
      .req_sel  (cfg_sel),
      .din      (sync_pipe[SYNC_STAGES-1]),
      .out_bit  (out[g]),
      .busy_bit (busy[g])
    );
  end

endmodule

// File: tb/tb_switch_mux.sv
// Bench for switch_mux: hand-derived vector table, directed reset/independence
// sequences and randomized traffic against a behavioural connection model.
module tb_switch_mux;

  localparam int NI   = 4;
  localparam int NO   = 4;
  localparam int SYNC = 2;
  localparam int GAP  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] in_r;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_out;
  logic [3:0]    cfg_sel;
  logic          cfg_en;
  logic          cfg_err;
  logic [NO-1:0] out;
  logic [NO-1:0] busy;

  int total = 0;
  int bad   = 0;

  switch_mux #(
    .INPUT_COUNT  (NI),
    .OUTPUT_COUNT (NO),
    .SYNC_STAGES  (SYNC),
    .GAP_CYCLES   (GAP),
    .IDLE_LEVEL   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_r),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_out   (cfg_out),
    .cfg_sel   (cfg_sel),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = disconnected, 1 = connected, 2 = waiting out the gap.
  int         m_mode [NO];
  int         m_sel  [NO];
  int         m_left [NO];
  int         m_pon  [NO];
  int         m_psel [NO];
  logic [3:0] hist [$];
  logic [3:0] m_out;
  logic [3:0] m_busy;
  logic       m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back(4'hF);
    for (int i = 0; i < NO; i++) begin
      m_mode[i] = 0; m_sel[i] = 0; m_left[i] = 0; m_pon[i] = 0; m_psel[i] = 0;
    end
    m_out = 4'hF; m_busy = 4'h0; m_err = 1'b0;
  endtask

  function automatic logic model_ready();
    if (int'(cfg_out) >= NO) return 1'b1;
    return m_mode[cfg_out] != 2;
  endfunction

  task automatic model_edge();
    logic [3:0] seen;
    logic       acc, inval;
    int         t;
    seen = hist.pop_front();
    hist.push_back(in_r);
    t     = int'(cfg_out);
    acc   = cfg_valid && model_ready();
    inval = (t >= NO) || (cfg_en && int'(cfg_sel) >= NI);
    for (int i = 0; i < NO; i++) begin
      if (m_mode[i] == 2) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_mode[i] = m_pon[i] ? 1 : 0;
          m_sel[i]  = m_psel[i];
        end
      end
    end
    if (acc && !inval) begin
      if (m_mode[t] == 0) begin
        if (cfg_en) begin m_mode[t] = 1; m_sel[t] = int'(cfg_sel); end
      end else if (m_mode[t] == 1) begin
        if (!cfg_en) begin
          m_mode[t] = 2; m_left[t] = GAP; m_pon[t] = 0; m_psel[t] = m_sel[t];
        end else if (int'(cfg_sel) != m_sel[t]) begin
          m_mode[t] = 2; m_left[t] = GAP; m_pon[t] = 1; m_psel[t] = int'(cfg_sel);
        end
      end
    end
    m_err = acc && inval;
    for (int i = 0; i < NO; i++) begin
      m_out[i]  = (m_mode[i] == 1) ? seen[m_sel[i]] : 1'b1;
      m_busy[i] = (m_mode[i] == 2);
    end
  endtask

  task automatic drive(input logic [3:0] iv, input logic v, input logic [3:0] o,
                       input logic [3:0] s, input logic e);
    in_r = iv; cfg_valid = v; cfg_out = o; cfg_sel = s; cfg_en = e;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_out",   32'(out),       32'(m_out));
    chk("model_busy",  32'(busy),      32'(m_busy));
    chk("model_err",   32'(cfg_err),   32'(m_err));
    chk("model_ready", 32'(cfg_ready), 32'(model_ready()));
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] iv;
    logic       v;
    logic [3:0] o;
    logic [3:0] s;
    logic       e;
    logic [3:0] x_out;
    logic [3:0] x_busy;
    logic       x_rdy;
    logic       x_err;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic [3:0] iv, logic v, logic [3:0] o, logic [3:0] s, logic e,
                              logic [3:0] xo, logic [3:0] xb, logic xr, logic xe);
    vec_t r;
    r.iv = iv; r.v = v; r.o = o; r.s = s; r.e = e;
    r.x_out = xo; r.x_busy = xb; r.x_rdy = xr; r.x_err = xe;
    return r;
  endfunction

  initial begin
    // connect 0<-2, follow in[2], two invalid requests, switch 0 to sel 1 through the gap
    tbl[0]  = mk(4'b0000, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[1]  = mk(4'b0000, 1, 0, 2, 1, 4'hF, 4'h0, 1, 0);
    tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 4'hE, 4'h0, 1, 0);
    tbl[3]  = mk(4'b0100, 0, 0, 0, 0, 4'hE, 4'h0, 1, 0);
    tbl[4]  = mk(4'b0100, 0, 0, 0, 0, 4'hE, 4'h0, 1, 0);
    tbl[5]  = mk(4'b0100, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[6]  = mk(4'b0000, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[8]  = mk(4'b0000, 0, 0, 0, 0, 4'hE, 4'h0, 1, 0);
    tbl[9]  = mk(4'b0000, 1, 5, 0, 1, 4'hE, 4'h0, 1, 1);
    tbl[10] = mk(4'b0000, 1, 0, 7, 1, 4'hE, 4'h0, 1, 1);
    tbl[11] = mk(4'b0000, 0, 0, 0, 0, 4'hE, 4'h0, 1, 0);
    tbl[12] = mk(4'b0000, 1, 0, 1, 1, 4'hF, 4'h1, 0, 0);
    tbl[13] = mk(4'b0010, 0, 0, 0, 0, 4'hF, 4'h1, 0, 0);
    tbl[14] = mk(4'b0010, 1, 0, 3, 1, 4'hF, 4'h1, 0, 0);
    tbl[15] = mk(4'b0010, 0, 0, 0, 0, 4'hF, 4'h1, 0, 0);
    tbl[16] = mk(4'b0010, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[17] = mk(4'b0000, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[18] = mk(4'b0000, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
    tbl[19] = mk(4'b0000, 0, 0, 0, 0, 4'hE, 4'h0, 1, 0);

    rst = 1'b1;
    drive(4'b0000, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out",   32'(out),       32'hF);
    chk("reset_busy",  32'(busy),      32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    chk("reset_err",   32'(cfg_err),   32'h0);
    rst = 1'b0;

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].iv, tbl[r].v, tbl[r].o, tbl[r].s, tbl[r].e);
      tick();
      chk($sformatf("tbl%0d_out", r),   32'(out),       32'(tbl[r].x_out));
      chk($sformatf("tbl%0d_busy", r),  32'(busy),      32'(tbl[r].x_busy));
      chk($sformatf("tbl%0d_ready", r), 32'(cfg_ready), 32'(tbl[r].x_rdy));
      chk($sformatf("tbl%0d_err", r),   32'(cfg_err),   32'(tbl[r].x_err));
    end

    // Output 1 onto in[3], then put output 0 into a gap and hit output 1 meanwhile.
    drive(4'b0000, 1, 1, 3, 1); tick();
    drive(4'b1000, 0, 0, 0, 0); repeat (4) tick();
    chk("conn1_out", 32'(out[1]), 32'h1);
    drive(4'b0000, 1, 0, 2, 1); tick();
    drive(4'b0000, 1, 1, 3, 1);
    #1 chk("indep_ready", 32'(cfg_ready), 32'h1);
    tick();
    chk("indep_out0",  32'(out[0]),  32'h1);
    chk("indep_busy0", 32'(busy[0]), 32'h1);
    chk("indep_busy1", 32'(busy[1]), 32'h0);
    drive(4'b1000, 0, 0, 0, 0); repeat (5) tick();

    // Disconnect output 1, then reset in the second gap clock.
    drive(4'b1000, 1, 1, 0, 0); tick();
    drive(4'b1000, 0, 1, 0, 0); tick();
    chk("disc_busy1", 32'(busy[1]), 32'h1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_out",  32'(out),     32'hF);
    chk("mid_rst_busy", 32'(busy),    32'h0);
    chk("mid_rst_err",  32'(cfg_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0001, 1, 1, 0, 1);
    #1 chk("post_rst_ready", 32'(cfg_ready), 32'h1);
    chk("post_rst_idle1", 32'(out[1]), 32'h1);
    tick();
    drive(4'b0001, 0, 0, 0, 0); repeat (3) tick();

    for (int n = 0; n < 1500; n++) begin
      drive(4'($urandom), ($urandom % 3) == 0, 4'($urandom_range(0, 5)),
            4'($urandom_range(0, 5)), ($urandom % 4) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
